// File: rtl/traffic_ctrl_param.sv
// Two-road traffic light controller with programmable phase lengths,
// pedestrian truncation of green and a flashing-yellow night mode.
module traffic_ctrl_param #(
   parameter int GREEN_A    = 6,
   parameter int GREEN_B    = 6,
   parameter int YELLOW     = 2,
   parameter int ALL_RED    = 1,
   parameter int MIN_GREEN  = 2,
   parameter int FLASH_HALF = 1,
   localparam int MAX_AB  = (GREEN_A > GREEN_B) ? GREEN_A : GREEN_B,
   localparam int MAX_YR  = (YELLOW > ALL_RED) ? YELLOW : ALL_RED,
   localparam int MAX_MF  = (MIN_GREEN > FLASH_HALF) ? MIN_GREEN : FLASH_HALF,
   localparam int MAX_2   = (MAX_AB > MAX_YR) ? MAX_AB : MAX_YR,
   localparam int MAX_D   = (MAX_2 > MAX_MF) ? MAX_2 : MAX_MF,
   localparam int CW      = $clog2(MAX_D) + 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       night,
   input  logic       ped_req,
   output logic [1:0] R,
   output logic [1:0] Y,
   output logic [1:0] G,
   output logic [2:0] phase,
   output logic       ped_pend
);

   localparam logic [2:0] A_GRN = 3'd0;
   localparam logic [2:0] A_YEL = 3'd1;
   localparam logic [2:0] CLR_A = 3'd2;
   localparam logic [2:0] B_GRN = 3'd3;
   localparam logic [2:0] B_YEL = 3'd4;
   localparam logic [2:0] CLR_B = 3'd5;
   localparam logic [2:0] FLASH = 3'd6;

   localparam logic [CW-1:0] GA_L = CW'(GREEN_A - 1);
   localparam logic [CW-1:0] GB_L = CW'(GREEN_B - 1);
   localparam logic [CW-1:0] YL_L = CW'(YELLOW - 1);
   localparam logic [CW-1:0] AR_L = CW'(ALL_RED - 1);
   localparam logic [CW-1:0] MG_L = CW'(MIN_GREEN - 1);
   localparam logic [CW-1:0] FH_L = CW'(FLASH_HALF - 1);

   logic [2:0]    state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          tog, tog_n;
   logic          pend_n;
   logic          want;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= CLR_B;
         cnt      <= '0;
         tog      <= 1'b0;
         ped_pend <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         tog      <= tog_n;
         ped_pend <= pend_n;
      end
   end

   // A request arriving on the truncation cycle itself ends green at once.
   assign want = ped_pend | ped_req;

   always_comb begin
      state_n = state;
      cnt_n   = cnt + 1'b1;
      tog_n   = tog;
      pend_n  = want;
      case (state)
         A_GRN: begin
            if (cnt == GA_L || (want && cnt >= MG_L)) begin
               state_n = A_YEL;
               pend_n  = 1'b0;
            end
         end
         A_YEL: if (cnt == YL_L) state_n = CLR_A;
         CLR_A: if (cnt == AR_L) state_n = night ? FLASH : B_GRN;
         B_GRN: begin
            if (cnt == GB_L || (want && cnt >= MG_L)) begin
               state_n = B_YEL;
               pend_n  = 1'b0;
            end
         end
         B_YEL: if (cnt == YL_L) state_n = CLR_B;
         CLR_B: if (cnt == AR_L) state_n = night ? FLASH : A_GRN;
         FLASH: begin
            pend_n = 1'b0;
            if (!night) begin
               state_n = CLR_B;
               tog_n   = 1'b0;
            end else if (cnt == FH_L) begin
               cnt_n = '0;
               tog_n = ~tog;
            end
         end
         default: begin
            state_n = CLR_B;
            tog_n   = 1'b0;
         end
      endcase
      if (state_n != state) cnt_n = '0;
      if (state_n == FLASH && state != FLASH) tog_n = 1'b1;
   end

   always_comb begin
      R     = 2'b11;
      Y     = 2'b00;
      G     = 2'b00;
      phase = state;
      case (state)
         A_GRN: begin R = 2'b10; G = 2'b01; end
         A_YEL: begin R = 2'b10; Y = 2'b01; end
         B_GRN: begin R = 2'b01; G = 2'b10; end
         B_YEL: begin R = 2'b01; Y = 2'b10; end
         FLASH: begin R = 2'b00; Y = {tog, tog}; end
         default: R = 2'b11;
      endcase
   end

endmodule

// File: tb/tb_traffic_ctrl_param.sv
// Bench for traffic_ctrl_param: directed scenarios plus random
// ped/night traffic, checked against an elapsed-time lamp model.
module tb_traffic_ctrl_param;

   localparam int GA = 6;
   localparam int GB = 6;
   localparam int YL = 2;
   localparam int AR = 1;
   localparam int MG = 2;
   localparam int FH = 1;

   logic       clk = 1'b0;
   logic       reset;
   logic       night;
   logic       ped_req;
   logic [1:0] R, Y, G;
   logic [2:0] phase;
   logic       ped_pend;

   int checks = 0;
   int errors = 0;

   int m_ph, m_el, m_tog, m_pend;

   traffic_ctrl_param #(
      .GREEN_A(GA), .GREEN_B(GB), .YELLOW(YL), .ALL_RED(AR),
      .MIN_GREEN(MG), .FLASH_HALF(FH)
   ) dut (
      .clk(clk), .reset(reset), .night(night), .ped_req(ped_req),
      .R(R), .Y(Y), .G(G), .phase(phase), .ped_pend(ped_pend)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   function automatic int dur(input int p);
      case (p)
         0: return GA;
         1: return YL;
         2: return AR;
         3: return GB;
         4: return YL;
         default: return AR;
      endcase
   endfunction

   // Lamps {R,Y,G} from which road currently owns the junction.
   function automatic int lamps(input int p, input int tg);
      logic [1:0] r, y, g;
      if (p == 6) begin
         r = 2'b00;
         g = 2'b00;
         y = (tg != 0) ? 2'b11 : 2'b00;
      end else begin
         r[0] = !(p == 0 || p == 1);
         r[1] = !(p == 3 || p == 4);
         g    = {p == 3, p == 0};
         y    = {p == 4, p == 1};
      end
      return int'({r, y, g});
   endfunction

   always @(posedge clk or posedge reset) begin
      int  ph, el, tg, pd;
      bit  green, done;
      if (reset) begin
         m_ph   <= 5;
         m_el   <= 0;
         m_tog  <= 0;
         m_pend <= 0;
      end else begin
         ph = m_ph;
         el = m_el;
         tg = m_tog;
         pd = m_pend;
         if (ph == 6) begin
            pd = 0;
            if (!night) begin
               ph = 5;
               el = 0;
               tg = 0;
            end else begin
               el = el + 1;
               if (el == FH) begin
                  el = 0;
                  tg = 1 - tg;
               end
            end
         end else begin
            green = (ph == 0 || ph == 3);
            done  = (el + 1 >= dur(ph)) ||
                    (green && (pd != 0 || ped_req) && el + 1 >= MG);
            pd    = (pd != 0 || ped_req) ? 1 : 0;
            if (done) begin
               if (green) pd = 0;
               if ((ph == 2 || ph == 5) && night) begin
                  ph = 6;
                  tg = 1;
               end else begin
                  ph = (ph + 1) % 6;
               end
               el = 0;
            end else begin
               el = el + 1;
            end
         end
         m_ph   <= ph;
         m_el   <= el;
         m_tog  <= tg;
         m_pend <= pd;
      end
   end

   always @(negedge clk) begin
      if (!reset) begin
         chk("phase", int'(phase), m_ph);
         chk("lamps", int'({R, Y, G}), lamps(m_ph, m_tog));
         chk("ped_pend", int'(ped_pend), m_pend);
         chk("safety_gg", int'(G[0] & G[1]), 0);
         if (phase != 3'd6)
            chk("safety_gy", int'((G[0] | Y[0]) & (G[1] | Y[1])), 0);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_enter(input int p);
      int n = 0;
      while (int'(phase) == p && n < 200) begin tick(); n++; end
      while (int'(phase) != p && n < 200) begin tick(); n++; end
      if (int'(phase) != p) chk("wait_timeout", int'(phase), p);
   endtask

   task automatic measure(input int p, output int n);
      n = 0;
      while (int'(phase) == p && n < 100) begin tick(); n++; end
   endtask

   task automatic check_cycle(input string name);
      int seq [18];
      int exp_seq [18];
      int v;
      exp_seq = '{5, 0, 0, 0, 0, 0, 0, 1, 1, 2, 3, 3, 3, 3, 3, 3, 4, 4};
      for (int k = 0; k < 36; k++) begin
         if (k > 0) tick();
         v = int'(phase);
         seq[k % 18] = v;
         if (v != exp_seq[k % 18]) chk(name, v, exp_seq[k % 18]);
      end
      chk({name, "_len_a"}, seq[6], 0);
      chk({name, "_len_b"}, seq[15], 3);
   endtask

   initial begin
      int n;
      reset   = 1'b1;
      night   = 1'b0;
      ped_req = 1'b0;
      tick();
      tick();
      chk("rst_phase", int'(phase), 5);
      chk("rst_lamps", int'({R, Y, G}), int'(6'b11_00_00));
      chk("rst_pend", int'(ped_pend), 0);
      reset = 1'b0;
      check_cycle("cycle1");

      wait_enter(0);
      ped_req = 1'b1;
      tick();
      ped_req = 1'b0;
      chk("t2_pend_set", int'(ped_pend), 1);
      chk("t2_still_grn", int'(phase), 0);
      tick();
      chk("t2_yel", int'(phase), 1);
      chk("t2_pend_clr", int'(ped_pend), 0);
      wait_enter(3);
      measure(3, n);
      chk("t2_bgrn_len", n, 6);

      wait_enter(0);
      repeat (4) tick();
      chk("t3_grn_cnt4", int'(phase), 0);
      ped_req = 1'b1;
      tick();
      ped_req = 1'b0;
      chk("t3_yel", int'(phase), 1);
      chk("t3_pend_clr", int'(ped_pend), 0);

      wait_enter(4);
      ped_req = 1'b1;
      tick();
      ped_req = 1'b0;
      chk("t4_pend_yel", int'(ped_pend), 1);
      tick();
      chk("t4_clr", int'(phase), 5);
      chk("t4_pend_clr", int'(ped_pend), 1);
      tick();
      measure(0, n);
      chk("t4_agrn_len", n, 2);

      wait_enter(0);
      night = 1'b1;
      wait_enter(2);
      tick();
      chk("t5_flash", int'(phase), 6);
      chk("t5_lamps_on", int'({R, Y, G}), int'(6'b00_11_00));
      tick();
      chk("t5_lamps_off", int'({R, Y, G}), int'(6'b00_00_00));
      tick();
      chk("t5_lamps_on2", int'(Y), 3);
      night = 1'b0;
      tick();
      chk("t5_exit_clr", int'(phase), 5);
      chk("t5_exit_red", int'(R), 3);
      tick();
      chk("t5_agrn", int'(phase), 0);

      wait_enter(3);
      tick();
      tick();
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("t6_async_phase", int'(phase), 5);
      chk("t6_async_lamps", int'({R, Y, G}), int'(6'b11_00_00));
      tick();
      reset = 1'b0;
      check_cycle("cycle2");

      repeat (3000) begin
         ped_req = (($urandom % 8) == 0);
         if (($urandom % 40) == 0) night = ~night;
         tick();
      end
      ped_req = 1'b0;
      night   = 1'b0;
      repeat (20) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
